mastermind_engine: RTL and testbench
====================================

Name: mastermind_engine

Overview:
- Parametrised Mastermind game core for the board game top level.
- Latches a secret code and accepts guesses over a valid/ready handshake.
- Scores each guess sequentially into exact/partial counts, tracks turns and win/lose, and stores a readable per-turn history.
- Generalises the fixed 4-peg, 3-bit, hard-wired design to any peg count, colour width and turn limit.

Parameters:
- PEGS, 4, pegs per code (>=1).
- COLOR_W, 3, bits per peg colour; 2**COLOR_W colours.
- MAX_TURNS, 8, guesses allowed per game (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- new_game  in  1  pulse; latches secret_in and starts a game.
- secret_in  in  PEGS*COLOR_W  secret code; peg i occupies bits [i*COLOR_W +: COLOR_W].
- guess_in  in  PEGS*COLOR_W  guess code, same packing.
- guess_valid  in  1  guess offered.
- guess_ready  out  1  engine can accept a guess.
- score_valid  out  1  one-cycle pulse; score outputs updated.
- exact_count  out  $clog2(PEGS+1)  right colour, right position.
- partial_count  out  $clog2(PEGS+1)  right colour, wrong position.
- turn_count  out  $clog2(MAX_TURNS+1)  guesses scored this game.
- game_over  out  1  game finished.
- win  out  1  last scored guess was all-exact.
- hist_rd_idx  in  $clog2(MAX_TURNS)  history read index (0 = first turn).
- hist_rd_guess  out  PEGS*COLOR_W  stored guess at hist_rd_idx.
- hist_rd_exact  out  $clog2(PEGS+1)  stored exact count.
- hist_rd_partial  out  $clog2(PEGS+1)  stored partial count.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including guess_ready, game_over, win, counts and turn_count.
  - History contents are don't-care; reads of unwritten entries return 0 because the valid bits clear.
- States: IDLE, PLAY, SCORE_PEG, SCORE_COLOR, REPORT, DONE.
- IDLE:
  - guess_ready = 0.
  - new_game latches secret_in, clears turn_count/win/game_over/counts/history valid bits, then -> PLAY.
- PLAY:
  - guess_ready = 1.
  - guess_valid && guess_ready (cycle T) latches guess_in, clears the histograms, then -> SCORE_PEG.
- SCORE_PEG, cycles T+1..T+PEGS, one peg per cycle:
  - Increment the exact accumulator on a match.
  - Increment the secret and guess per-colour histograms for that peg.
- SCORE_COLOR, cycles T+PEGS+1..T+PEGS+2**COLOR_W, one colour per cycle:
  - Accumulate min(secret_hist[c], guess_hist[c]).
- REPORT, cycle T+PEGS+2**COLOR_W+1:
  - exact_count = exact; partial_count = sum_min - exact.
  - score_valid = 1 for this cycle only.
  - turn_count increments; history entry [turn_count_old] is written.
  - If exact == PEGS: win = 1, game_over = 1, -> DONE.
  - Else if the new turn_count == MAX_TURNS: game_over = 1, win = 0, -> DONE.
  - Else -> PLAY.
- Score latency: score_valid exactly PEGS + 2**COLOR_W + 1 cycles after acceptance. Defaults give 13.
- DONE: guess_ready = 0; guesses are ignored; outputs hold until new_game.
- guess_ready = 0 in every state except PLAY. guess_valid while not ready is dropped, not queued.
- new_game in any state, including mid-scoring:
  - Aborts scoring and restarts as described for IDLE.
  - No score_valid is emitted for the aborted guess.
  - new_game wins over a simultaneous guess_valid.
- reset wins over new_game.
- Winning on turn MAX_TURNS reports win = 1, not loss.
- Widths:
  - Histogram counters are $clog2(PEGS+1) bits and cannot overflow.
  - The min-sum accumulator is at least $clog2(PEGS+1) bits.
  - partial_count is never negative, because sum_min >= exact always.
- History reads are combinational from hist_rd_idx.
  - Indexes >= turn_count, or >= MAX_TURNS, return all zeros.

Optional Feature:
- Macro: MASTERMIND_HISTORY_EN.
- Defined: the MAX_TURNS-entry history buffer and read port operate as described.
- Undefined: no history storage is built; hist_rd_guess, hist_rd_exact and hist_rd_partial are tied to 0. All other behaviour is identical.

Test Plan:
- Defaults; new_game with secret pegs {0:1, 1:2, 2:3, 3:4}; guess {1,2,3,4} -> score_valid 13 cycles after accept, exact 4, partial 0, win 1, game_over 1, turn_count 1, guess_ready 0.
- Same secret; guess {4,3,2,1} -> exact 0, partial 4, win 0, guess_ready back to 1 the cycle after REPORT.
- Same secret; guess {1,1,2,2} -> exact 1, partial 1. Then guess {5,6,7,0} -> exact 0, partial 0. History (macro on): idx0 returns {1,1,2,2}/1/1, idx1 returns {5,6,7,0}/0/0, idx2 returns 0.
- Eight non-winning guesses -> game_over 1 and win 0 after the 8th; a 9th guess_valid gets no ready and no score_valid; new_game clears turn_count to 0.
- new_game asserted 5 cycles into scoring -> no score_valid; turn_count 0; guess_ready 1 the next cycle. reset asserted mid-SCORE_COLOR -> all outputs 0 the next cycle.
- Macro off: after a scored guess, hist_rd_* read 0 for all indexes; scores and latency are unchanged.

Source files
------------

// File: rtl/mastermind_engine.sv
// mastermind_engine: parametrised Mastermind core; scores guesses one peg, then one colour, per cycle.
// Optional per-turn history buffer and read port: define MASTERMIND_HISTORY_EN.
module mastermind_engine #(
    parameter int PEGS      = 4,
    parameter int COLOR_W   = 3,
    parameter int MAX_TURNS = 8
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          new_game,
    input  logic [PEGS*COLOR_W-1:0]                       secret_in,
    input  logic [PEGS*COLOR_W-1:0]                       guess_in,
    input  logic                                          guess_valid,
    output logic                                          guess_ready,
    output logic                                          score_valid,
    output logic [$clog2(PEGS+1)-1:0]                     exact_count,
    output logic [$clog2(PEGS+1)-1:0]                     partial_count,
    output logic [$clog2(MAX_TURNS+1)-1:0]                turn_count,
    output logic                                          game_over,
    output logic                                          win,
    input  logic [((MAX_TURNS>1)?$clog2(MAX_TURNS):1)-1:0] hist_rd_idx,
    output logic [PEGS*COLOR_W-1:0]                       hist_rd_guess,
    output logic [$clog2(PEGS+1)-1:0]                     hist_rd_exact,
    output logic [$clog2(PEGS+1)-1:0]                     hist_rd_partial
);

    localparam int CODE_W = PEGS * COLOR_W;
    localparam int CNT_W  = $clog2(PEGS + 1);
    localparam int TURN_W = $clog2(MAX_TURNS + 1);
    localparam int HIDX_W = (MAX_TURNS > 1) ? $clog2(MAX_TURNS) : 1;
    localparam int PIDX_W = (PEGS > 1) ? $clog2(PEGS) : 1;
    localparam int NCOL   = 1 << COLOR_W;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        SCORE_PEG,
        SCORE_COLOR,
        REPORT,
        DONE
    } state_t;

    state_t              state_q;
    logic [CODE_W-1:0]   secret_q;
    logic [CODE_W-1:0]   guess_q;
    logic [PIDX_W-1:0]   peg_q;
    logic [COLOR_W-1:0]  col_q;
    logic [CNT_W-1:0]    exact_q;
    logic [CNT_W-1:0]    sum_q;
    logic [CNT_W-1:0]    shist_q [NCOL];
    logic [CNT_W-1:0]    ghist_q [NCOL];
    logic                guess_ready_q;
    logic                score_valid_q;
    logic                game_over_q;
    logic                win_q;
    logic [CNT_W-1:0]    exact_count_q;
    logic [CNT_W-1:0]    partial_count_q;
    logic [TURN_W-1:0]   turn_count_q;

    logic [COLOR_W-1:0]  speg;
    logic [COLOR_W-1:0]  gpeg;
    logic [CNT_W-1:0]    min_c;
    logic [CNT_W-1:0]    sum_d;
    logic [CNT_W-1:0]    exact_d;
    logic [CNT_W-1:0]    partial_d;
    logic [TURN_W-1:0]   turn_d;
    logic                last_peg;
    logic                last_col;

    assign guess_ready   = guess_ready_q;
    assign score_valid   = score_valid_q;
    assign exact_count   = exact_count_q;
    assign partial_count = partial_count_q;
    assign turn_count    = turn_count_q;
    assign game_over     = game_over_q;
    assign win           = win_q;

    // Select the current peg pair and form the next accumulator values
    always_comb begin
        speg = '0;
        gpeg = '0;
        for (int i = 0; i < PEGS; i++) begin
            if (peg_q == PIDX_W'(i)) begin
                speg = secret_q[i*COLOR_W +: COLOR_W];
                gpeg = guess_q[i*COLOR_W +: COLOR_W];
            end
        end
        min_c     = (shist_q[col_q] < ghist_q[col_q]) ? shist_q[col_q] : ghist_q[col_q];
        sum_d     = sum_q + min_c;
        exact_d   = exact_q + CNT_W'(speg == gpeg);
        partial_d = sum_d - exact_q;
        turn_d    = turn_count_q + TURN_W'(1);
        last_peg  = (peg_q == PIDX_W'(PEGS - 1));
        last_col  = &col_q;
    end

    // Game FSM: accept, score peg-by-peg then colour-by-colour, report, end game
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            secret_q        <= '0;
            guess_q         <= '0;
            peg_q           <= '0;
            col_q           <= '0;
            exact_q         <= '0;
            sum_q           <= '0;
            guess_ready_q   <= 1'b0;
            score_valid_q   <= 1'b0;
            game_over_q     <= 1'b0;
            win_q           <= 1'b0;
            exact_count_q   <= '0;
            partial_count_q <= '0;
            turn_count_q    <= '0;
            for (int c = 0; c < NCOL; c++) begin
                shist_q[c] <= '0;
                ghist_q[c] <= '0;
            end
        end else if (new_game) begin
            state_q         <= PLAY;
            secret_q        <= secret_in;
            guess_ready_q   <= 1'b1;
            score_valid_q   <= 1'b0;
            game_over_q     <= 1'b0;
            win_q           <= 1'b0;
            exact_count_q   <= '0;
            partial_count_q <= '0;
            turn_count_q    <= '0;
        end else begin
            score_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                end
                PLAY: begin
                    if (guess_valid) begin
                        guess_q       <= guess_in;
                        guess_ready_q <= 1'b0;
                        peg_q         <= '0;
                        col_q         <= '0;
                        exact_q       <= '0;
                        sum_q         <= '0;
                        for (int c = 0; c < NCOL; c++) begin
                            shist_q[c] <= '0;
                            ghist_q[c] <= '0;
                        end
                        state_q <= SCORE_PEG;
                    end
                end
                SCORE_PEG: begin
                    exact_q       <= exact_d;
                    shist_q[speg] <= shist_q[speg] + CNT_W'(1);
                    ghist_q[gpeg] <= ghist_q[gpeg] + CNT_W'(1);
                    peg_q         <= peg_q + PIDX_W'(1);
                    if (last_peg) begin
                        state_q <= SCORE_COLOR;
                    end
                end
                SCORE_COLOR: begin
                    sum_q <= sum_d;
                    col_q <= col_q + COLOR_W'(1);
                    if (last_col) begin
                        exact_count_q   <= exact_q;
                        partial_count_q <= partial_d;
                        score_valid_q   <= 1'b1;
                        turn_count_q    <= turn_d;
                        if (exact_q == CNT_W'(PEGS)) begin
                            win_q       <= 1'b1;
                            game_over_q <= 1'b1;
                        end else if (turn_d == TURN_W'(MAX_TURNS)) begin
                            win_q       <= 1'b0;
                            game_over_q <= 1'b1;
                        end
                        state_q <= REPORT;
                    end
                end
                REPORT: begin
                    if (game_over_q) begin
                        state_q <= DONE;
                    end else begin
                        state_q       <= PLAY;
                        guess_ready_q <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MASTERMIND_HISTORY_EN
    logic [CODE_W-1:0]    hg_q [MAX_TURNS];
    logic [CNT_W-1:0]     he_q [MAX_TURNS];
    logic [CNT_W-1:0]     hp_q [MAX_TURNS];
    logic [MAX_TURNS-1:0] hv_q;
    logic                 hist_we;
    logic [HIDX_W-1:0]    wr_idx;

    assign hist_we = (state_q == SCORE_COLOR) && last_col && !new_game && !reset;
    assign wr_idx  = HIDX_W'(turn_count_q);

    // Valid bits gate reads so stale entries from a prior game read as zero
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            hv_q <= '0;
        end else if (hist_we) begin
            hv_q[wr_idx] <= 1'b1;
        end
    end

    // Entry payload is written alongside the score report
    always_ff @(posedge clk) begin
        if (hist_we) begin
            hg_q[wr_idx] <= guess_q;
            he_q[wr_idx] <= exact_q;
            hp_q[wr_idx] <= partial_d;
        end
    end

    // Combinational read; unwritten or out-of-range indexes give zero
    always_comb begin
        hist_rd_guess   = '0;
        hist_rd_exact   = '0;
        hist_rd_partial = '0;
        for (int t = 0; t < MAX_TURNS; t++) begin
            if (hist_rd_idx == HIDX_W'(t) && hv_q[t]) begin
                hist_rd_guess   = hg_q[t];
                hist_rd_exact   = he_q[t];
                hist_rd_partial = hp_q[t];
            end
        end
    end
`else
    logic unused_hist_idx;

    assign unused_hist_idx = ^hist_rd_idx;
    assign hist_rd_guess   = '0;
    assign hist_rd_exact   = '0;
    assign hist_rd_partial = '0;
`endif

endmodule

// File: tb/tb_mastermind_engine.sv
// tb_mastermind_engine: scoreboard bench for mastermind_engine at default parameters.
// Expected scores come from a mark-and-strike model, queued at accept and popped on score_valid.
module tb_mastermind_engine;

    localparam int PEGS = 4;
    localparam int CW   = 3;
    localparam int MT   = 8;
    localparam int LAT  = PEGS + (1 << CW) + 1;

    typedef struct {
        int ex;
        int pa;
        int w;
        int go;
        int turn;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        new_game;
    logic [11:0] secret_in;
    logic [11:0] guess_in;
    logic        guess_valid;
    logic        guess_ready;
    logic        score_valid;
    logic [2:0]  exact_count;
    logic [2:0]  partial_count;
    logic [3:0]  turn_count;
    logic        game_over;
    logic        win;
    logic [2:0]  hist_rd_idx;
    logic [11:0] hist_rd_guess;
    logic [2:0]  hist_rd_exact;
    logic [2:0]  hist_rd_partial;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    logic [11:0] m_secret;
    int          m_turn;
    logic [11:0] m_hg [MT];
    int          m_he [MT];
    int          m_hp [MT];

    mastermind_engine #(
        .PEGS(PEGS),
        .COLOR_W(CW),
        .MAX_TURNS(MT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .new_game(new_game),
        .secret_in(secret_in),
        .guess_in(guess_in),
        .guess_valid(guess_valid),
        .guess_ready(guess_ready),
        .score_valid(score_valid),
        .exact_count(exact_count),
        .partial_count(partial_count),
        .turn_count(turn_count),
        .game_over(game_over),
        .win(win),
        .hist_rd_idx(hist_rd_idx),
        .hist_rd_guess(hist_rd_guess),
        .hist_rd_exact(hist_rd_exact),
        .hist_rd_partial(hist_rd_partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [2:0] peg(input logic [11:0] code, input int i);
        logic [11:0] t;
        t = code >> (3 * i);
        return t[2:0];
    endfunction

    function automatic logic [11:0] pack4(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    // Classic marking: strike exact pairs, then match leftovers one-to-one
    function automatic void model_score(input logic [11:0] s, input logic [11:0] g,
                                        output int ex, output int pa);
        bit su[4];
        bit gu[4];
        ex = 0;
        pa = 0;
        for (int i = 0; i < 4; i++) begin
            su[i] = 1'b0;
            gu[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (peg(s, i) == peg(g, i)) begin
                ex++;
                su[i] = 1'b1;
                gu[i] = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!gu[i]) begin
                for (int j = 0; j < 4; j++) begin
                    if (!su[j] && peg(s, j) == peg(g, i)) begin
                        pa++;
                        su[j] = 1'b1;
                        break;
                    end
                end
            end
        end
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin : mon
        exp_t e;
        if (score_valid) begin
            if (sb.size() == 0) begin
                check("spurious_score", 32'(score_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check("exact", 32'(exact_count), 32'(e.ex));
                check("partial", 32'(partial_count), 32'(e.pa));
                check("win", 32'(win), 32'(e.w));
                check("game_over", 32'(game_over), 32'(e.go));
                check("turn", 32'(turn_count), 32'(e.turn));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_game(input logic [11:0] s);
        @(negedge clk);
        new_game  = 1'b1;
        secret_in = s;
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b0;
        m_secret = s;
        m_turn   = 0;
    endtask

    // Drives a guess until accepted; returns at the negedge of the first scoring cycle
    task automatic send_guess(input logic [11:0] g, output bit ok);
        int n;
        @(negedge clk);
        guess_valid = 1'b1;
        guess_in    = g;
        n = 0;
        while (!guess_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = guess_ready;
        if (!ok) begin
            check("ready_timeout", 32'(0), 32'(1));
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        guess_valid = 1'b0;
    endtask

    // Full turn: accept, queue the model result, wait for the report
    task automatic play(input logic [11:0] g);
        bit   ok;
        int   lat;
        exp_t e;
        send_guess(g, ok);
        if (ok) begin
            model_score(m_secret, g, e.ex, e.pa);
            m_hg[m_turn] = g;
            m_he[m_turn] = e.ex;
            m_hp[m_turn] = e.pa;
            m_turn++;
            e.w    = (e.ex == PEGS) ? 1 : 0;
            e.go   = (e.w == 1 || m_turn == MT) ? 1 : 0;
            e.turn = m_turn;
            sb.push_back(e);
            lat = 1;
            while (!score_valid && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            if (!score_valid) check("score_timeout", 32'(0), 32'(1));
            else check("latency", 32'(lat), 32'(LAT));
        end
    endtask

    task automatic hist_sweep();
        logic [11:0] eg;
        int          ee;
        int          ep;
        for (int i = 0; i < MT; i++) begin
            eg = '0;
            ee = 0;
            ep = 0;
`ifdef MASTERMIND_HISTORY_EN
            if (i < m_turn) begin
                eg = m_hg[i];
                ee = m_he[i];
                ep = m_hp[i];
            end
`endif
            hist_rd_idx = 3'(i);
            #1;
            check($sformatf("hist_guess[%0d]", i), 32'(hist_rd_guess), 32'(eg));
            check($sformatf("hist_exact[%0d]", i), 32'(hist_rd_exact), 32'(ee));
            check($sformatf("hist_part[%0d]", i), 32'(hist_rd_partial), 32'(ep));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(guess_ready), 32'(0));
        check({tag, "_sv"}, 32'(score_valid), 32'(0));
        check({tag, "_exact"}, 32'(exact_count), 32'(0));
        check({tag, "_partial"}, 32'(partial_count), 32'(0));
        check({tag, "_turn"}, 32'(turn_count), 32'(0));
        check({tag, "_go"}, 32'(game_over), 32'(0));
        check({tag, "_win"}, 32'(win), 32'(0));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [11:0] sec;
        logic [11:0] g;
        bit          ok;
        int          any_ready;
        reset       = 1'b0;
        new_game    = 1'b0;
        secret_in   = '0;
        guess_in    = '0;
        guess_valid = 1'b0;
        hist_rd_idx = '0;
        m_turn      = 0;
        m_secret    = '0;
        sec         = pack4(1, 2, 3, 4);

        do_reset();
        check_all_zero("reset");
        hist_sweep();

        // Winning first guess
        start_game(sec);
        check("ready_after_new", 32'(guess_ready), 32'(1));
        play(pack4(1, 2, 3, 4));
        check("ready_in_report_win", 32'(guess_ready), 32'(0));
        @(negedge clk);
        check("done_ready", 32'(guess_ready), 32'(0));
        check("done_go", 32'(game_over), 32'(1));
        check("done_win", 32'(win), 32'(1));

        // All colours right, none placed
        start_game(sec);
        play(pack4(4, 3, 2, 1));
        check("ready_in_report", 32'(guess_ready), 32'(0));
        @(negedge clk);
        check("ready_after_report", 32'(guess_ready), 32'(1));

        // Mixed score, then a miss, then history
        start_game(sec);
        play(pack4(1, 1, 2, 2));
        play(pack4(5, 6, 7, 0));
        @(negedge clk);
        hist_sweep();

        // Eight losing guesses, then a guess in DONE
        start_game(sec);
        for (int t = 0; t < MT; t++) begin
            g = 12'($urandom);
            if (g == sec) g = g ^ 12'h001;
            play(g);
        end
        @(negedge clk);
        check("loss_go", 32'(game_over), 32'(1));
        check("loss_win", 32'(win), 32'(0));
        hist_sweep();
        guess_valid = 1'b1;
        guess_in    = pack4(1, 2, 3, 4);
        any_ready   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (guess_ready) any_ready = 1;
        end
        guess_valid = 1'b0;
        check("ready_in_done", 32'(any_ready), 32'(0));
        start_game(sec);
        check("new_turn", 32'(turn_count), 32'(0));
        check("new_go", 32'(game_over), 32'(0));

        // Win exactly on the last turn
        for (int t = 0; t < MT - 1; t++) play(pack4(0, 0, 0, 0));
        play(sec);
        @(negedge clk);
        check("lastturn_win", 32'(win), 32'(1));
        check("lastturn_turn", 32'(turn_count), 32'(MT));

        // new_game five cycles into scoring aborts the guess
        start_game(sec);
        send_guess(pack4(4, 3, 2, 1), ok);
        idle_cycles(4);
        new_game  = 1'b1;
        secret_in = sec;
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b0;
        m_turn   = 0;
        check("abort_turn", 32'(turn_count), 32'(0));
        check("abort_ready", 32'(guess_ready), 32'(1));
        idle_cycles(20);

        // new_game beats a simultaneous guess
        @(negedge clk);
        new_game    = 1'b1;
        guess_valid = 1'b1;
        guess_in    = pack4(1, 2, 3, 4);
        @(posedge clk);
        @(negedge clk);
        new_game    = 1'b0;
        guess_valid = 1'b0;
        check("race_ready", 32'(guess_ready), 32'(1));
        idle_cycles(20);
        check("race_turn", 32'(turn_count), 32'(0));

        // reset during colour scoring
        play(pack4(2, 1, 4, 3));
        @(negedge clk);
        check("pre_reset_turn", 32'(turn_count), 32'(1));
        send_guess(pack4(1, 2, 3, 5), ok);
        idle_cycles(6);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset");
        reset  = 1'b0;
        m_turn = 0;
        hist_sweep();
        idle_cycles(20);

        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
